seq_adder_sub: RTL and testbench
================================

Name: seq_adder_sub

Overview:
Multi-cycle, parametrised adder/subtractor for the ALU datapath. It generalises the fixed 6-bit ripple-carry full adder: operands of WIDTH bits are processed CHUNK bits per clock through one reused ripple slice. The block adds a subtract mode, carry and signed-overflow flags, and a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width; must be a multiple of CHUNK and at least CHUNK.
- CHUNK, 2, bits summed per clock (ripple slice width); N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled on the rising edge.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse: result and flags are valid.
- s  output  WIDTH  result.
- carry_out  output  1  carry out of MSB. For subtract, 1 = no borrow.
- overflow  output  1  two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, s=0, carry_out=0, overflow=0, slice index=0. Reset overrides every other input on the same edge, including mid-operation. An aborted operation produces no done pulse.
- States:
  - IDLE: start=1 latches a, b XOR {WIDTH{mode}}, and carry=mode into internal registers. It clears s, sets index=0, and moves to RUN.
  - RUN: busy=1. Each edge adds slice [index*CHUNK +: CHUNK] of the latched operands with the running carry and writes the sum into the same slice of s. It updates carry and increments index. The edge that processes slice N-1 moves to DONE.
  - DONE: done=1 for exactly one cycle, busy=0. The next edge returns to IDLE. If start=1 on that edge, a new operation is accepted and the state moves directly to RUN (back-to-back operation).
- Latency: start is sampled on edge k; done=1 during the cycle after edge k+N. Throughput is one operation per N+1 cycles.
- Flags, updated on the last slice only:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
  - Before the first completed operation, both flags are 0.
- Output hold: s, carry_out and overflow stay at the last result until the next accepted start. At that point s is cleared and the flags hold until the final slice.
- Ignored inputs:
  - start is ignored in RUN.
  - a, b and mode are ignored except on the accepting edge; changes during RUN do not affect the result.
- Arithmetic: modulo 2^WIDTH. Subtract is implemented as a + ~b + 1; the +1 enters as the initial carry.
- Slice index width: clog2(N), minimum 1 bit. It wraps to 0 when the next operation is accepted.

Decomposition:
- Shared ALU package or include file:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1.
- Sub-module adder_slice #(CHUNK): a combinational ripple of CHUNK full adders built from the existing full adder cell.
  - Inputs: a_s, b_s, cin.
  - Outputs: sum, cout, and c_msb (carry into the slice MSB, used for overflow).
- The FSM, operand registers and index counter live in seq_adder_sub.

Test Plan:
All scenarios use WIDTH=8, CHUNK=2 (N=4) unless stated otherwise.
1. start with a=8'h0F, b=8'h01, mode=0 on edge k -> busy=1 for 4 cycles; done=1 in the cycle after edge k+4 only; s=8'h10, carry_out=0, overflow=0.
2. Add 8'h7F+8'h01 -> s=8'h80, carry_out=0, overflow=1. Add 8'hFF+8'h01 -> s=8'h00, carry_out=1, overflow=0.
3. Subtract 8'h05-8'h07 -> s=8'hFE, carry_out=0, overflow=0. Subtract 8'h80-8'h01 -> s=8'h7F, carry_out=1, overflow=1.
4. Assert reset for one cycle, 2 edges after start -> next cycle busy=0, done=0, s=0, flags 0, and no done pulse follows. A fresh start of 8'h03+8'h04 then gives s=8'h07 with normal latency.
5. Hold start=1 and change a to 8'hAA during RUN of 8'h10+8'h20 -> result is s=8'h30 (changes ignored). The start still high in DONE is accepted: busy=1 on the next cycle, and the new result is 8'hAA+8'h20=8'hCA.
6. Instance with WIDTH=16, CHUNK=4: 16'hFFFF+16'h0001 -> done 4 edges after start, s=16'h0000, carry_out=1, overflow=0.

Source files
------------

// File: rtl/seq_adder_sub_pkg.sv
// rtl/seq_adder_sub_pkg.sv - shared ALU constants for the sequential adder/subtractor
package seq_adder_sub_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Slice index width, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/seq_adder_sub_if.sv
// rtl/seq_adder_sub_if.sv - operand/result handshake bundle for seq_adder_sub
interface seq_adder_sub_if #(parameter int WIDTH = 8);

   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             carry_out;
   logic             overflow;

   modport master (output start, mode, a, b,
                   input  busy, done, s, carry_out, overflow);

   modport slave  (input  start, mode, a, b,
                   output busy, done, s, carry_out, overflow);

endinterface

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CHUNK-bit ripple of full adder cells
module adder_slice #(
   parameter int CHUNK = 2
) (
   input  logic [CHUNK-1:0] a_s,
   input  logic [CHUNK-1:0] b_s,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      full_adder u_fa (
         .a    (a_s[i]),
         .b    (b_s[i]),
         .cin  (c[i]),
         .sum  (sum[i]),
         .cout (c[i+1])
      );
   end

   assign cout  = c[CHUNK];
   assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/seq_adder_sub.sv
// rtl/seq_adder_sub.sv - multi-cycle WIDTH-bit add/subtract, CHUNK bits per clock
module seq_adder_sub
   import seq_adder_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic            clk,
   input  logic            reset,
   seq_adder_sub_if.slave  bus
);

   localparam int N  = WIDTH / CHUNK;
   localparam int IW = idx_width(N);

   logic [1:0]       state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] s_q;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;
   logic [IW-1:0]    idx;

   logic [31:0]      base;
   logic [CHUNK-1:0] a_s;
   logic [CHUNK-1:0] b_s;
   logic [CHUNK-1:0] sum;
   logic             sl_cout;
   logic             sl_cmsb;
   logic             last;

   assign base = 32'(idx) * 32'(CHUNK);
   assign a_s  = op_a[base +: CHUNK];
   assign b_s  = op_b[base +: CHUNK];
   assign last = (idx == IW'(N - 1));

   adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a_s   (a_s),
      .b_s   (b_s),
      .cin   (carry),
      .sum   (sum),
      .cout  (sl_cout),
      .c_msb (sl_cmsb)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         op_a   <= '0;
         op_b   <= '0;
         s_q    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         idx    <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               s_q[base +: CHUNK] <= sum;
               carry              <= sl_cout;
               idx                <= idx + 1'b1;
               if (last) begin
                  cout_q <= sl_cout;
                  ovf_q  <= sl_cmsb ^ sl_cout;
                  state  <= ST_DONE;
               end
            end
            // IDLE and DONE both accept a new operation; subtract folds into ~b with carry-in 1.
            default: begin
               if (bus.start) begin
                  op_a  <= bus.a;
                  op_b  <= bus.b ^ {WIDTH{bus.mode}};
                  carry <= (bus.mode == MODE_SUB);
                  s_q   <= '0;
                  idx   <= '0;
                  state <= ST_RUN;
               end else begin
                  state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy      = (state == ST_RUN);
   assign bus.done      = (state == ST_DONE);
   assign bus.s         = s_q;
   assign bus.carry_out = cout_q;
   assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_seq_adder_sub.sv
// tb/tb_seq_adder_sub.sv - directed self-checking bench for seq_adder_sub
module tb_seq_adder_sub;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   seq_adder_sub_if #(.WIDTH(8))  bus8 ();
   seq_adder_sub_if #(.WIDTH(16)) bus16 ();

   seq_adder_sub #(.WIDTH(8), .CHUNK(2)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   seq_adder_sub #(.WIDTH(16), .CHUNK(4)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Start an 8-bit operation at a negedge, follow it through RUN and check the DONE cycle.
   task automatic op8(input string tag, input logic m, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] es, input logic ec, input logic ev);
      bus8.start = 1'b1;
      bus8.mode  = m;
      bus8.a     = av;
      bus8.b     = bv;
      @(negedge clk);
      bus8.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_busy"}, {30'd0, bus8.busy, bus8.done}, 32'h2);
         @(negedge clk);
      end
      chk({tag, "_done"}, {30'd0, bus8.busy, bus8.done}, 32'h1);
      chk({tag, "_s"}, {24'd0, bus8.s}, {24'd0, es});
      chk({tag, "_flags"}, {30'd0, bus8.carry_out, bus8.overflow}, {30'd0, ec, ev});
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, bus8.done}, 32'h0);
   endtask

   initial begin
      int seen_done;
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      bus8.start  = 1'b0;
      bus8.mode   = 1'b0;
      bus8.a      = '0;
      bus8.b      = '0;
      bus16.start = 1'b0;
      bus16.mode  = 1'b0;
      bus16.a     = '0;
      bus16.b     = '0;
      repeat (3) @(negedge clk);
      chk("rst_state", {27'd0, bus8.busy, bus8.done, bus8.carry_out, bus8.overflow, 1'b0}, 32'h0);
      chk("rst_s", {24'd0, bus8.s}, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      op8("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0);
      op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
      op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      op8("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
      op8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

      // Abort mid-operation: reset sampled two edges after the accepting edge.
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      bus8.a     = 8'h11;
      bus8.b     = 8'h22;
      @(negedge clk);
      bus8.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_state", {28'd0, bus8.busy, bus8.done, bus8.carry_out, bus8.overflow}, 32'h0);
      chk("abort_s", {24'd0, bus8.s}, 32'h0);
      seen_done = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus8.done) seen_done++;
      end
      chk("abort_no_done", seen_done, 0);
      op8("add_03_04", 1'b0, 8'h03, 8'h04, 8'h07, 1'b0, 1'b0);

      // Inputs changed during RUN are ignored; start held high is taken again from DONE.
      bus8.start = 1'b1;
      bus8.mode  = 1'b0;
      bus8.a     = 8'h10;
      bus8.b     = 8'h20;
      @(negedge clk);
      bus8.a = 8'hAA;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_busy1", {30'd0, bus8.busy, bus8.done}, 32'h2);
         @(negedge clk);
      end
      chk("b2b_done1", {30'd0, bus8.busy, bus8.done}, 32'h1);
      chk("b2b_s1", {24'd0, bus8.s}, 32'h30);
      @(negedge clk);
      bus8.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("b2b_busy2", {30'd0, bus8.busy, bus8.done}, 32'h2);
         @(negedge clk);
      end
      chk("b2b_done2", {30'd0, bus8.busy, bus8.done}, 32'h1);
      chk("b2b_s2", {24'd0, bus8.s}, 32'hCA);
      chk("b2b_flags2", {30'd0, bus8.carry_out, bus8.overflow}, 32'h0);
      @(negedge clk);
      chk("hold_s", {24'd0, bus8.s}, 32'hCA);

      // 16-bit instance, 4-bit slices.
      bus16.start = 1'b1;
      bus16.mode  = 1'b0;
      bus16.a     = 16'hFFFF;
      bus16.b     = 16'h0001;
      @(negedge clk);
      bus16.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("w16_busy", {30'd0, bus16.busy, bus16.done}, 32'h2);
         @(negedge clk);
      end
      chk("w16_done", {30'd0, bus16.busy, bus16.done}, 32'h1);
      chk("w16_s", {16'd0, bus16.s}, 32'h0);
      chk("w16_flags", {30'd0, bus16.carry_out, bus16.overflow}, 32'h2);
      @(negedge clk);
      chk("w16_pulse", {31'd0, bus16.done}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
